scan_reg_bank: RTL and testbench

- Parametrised successor to the single-bit scan flop: a WIDTH-bit functional register with a shadow scan chain.
- Configuration words are shifted in serially, then transferred atomically to the live register by an update strobe.
- Readback uses a capture strobe.
- Adds a shift counter and a fill-state FSM so software/test logic knows when a full word is staged.

---
 rtl/scan_reg_bank.sv | 108 ++++++++++
 tb/tb_scan_reg_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_reg_bank.sv
// scan_reg_bank: WIDTH-bit live register q with a shadow scan chain, a shift counter and a fill-state FSM.
// Define SCAN_PARITY_EN to append an odd-parity bit behind the data in the chain and check it on update.
module scan_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = $clog2(WIDTH + 2)
) (
    input  logic             flop_clk,
    input  logic             rst,
    input  logic             set,
    input  logic             load_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic             shift_en,
    input  logic             shift_i,
    output logic             shift_o,
    input  logic             capture,
    input  logic             update,
    output logic             shift_full,
    output logic             upd_ack,
    output logic             upd_err
);

`ifdef SCAN_PARITY_EN
    localparam int CHAIN_W = WIDTH + 1;
`else
    localparam int CHAIN_W = WIDTH;
`endif
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_W);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t             state, state_next;
    logic [CHAIN_W-1:0] shadow, capture_word;
    logic [WIDTH-1:0]   shadow_data;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               upd_ok, par_ok, upd_take;

`ifdef SCAN_PARITY_EN
    // Parity sits at shadow[0], behind the data word.
    assign shadow_data  = shadow[CHAIN_W-1:1];
    assign capture_word = {q, ~^q};
    assign par_ok       = ^shadow;
`else
    assign shadow_data  = shadow;
    assign capture_word = q;
    assign par_ok       = 1'b1;
`endif

    // A full chain is accepted only when not shifting; a bad parity still consumes the word.
    assign upd_ok   = update && (state == FULL) && !shift_en;
    assign upd_take = upd_ok && par_ok;
    assign shift_o  = shadow[CHAIN_W-1];

    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        cnt_next   = cnt;
        state_next = state;
        if (shift_en) begin
            if (cnt != CNT_FULL)
                cnt_next = cnt + 1'b1;
        end else if (capture) begin
            cnt_next = CNT_FULL;
        end else if (upd_ok) begin
            cnt_next = '0;
        end

        if (cnt_next == CNT_FULL)
            state_next = FULL;
        else if (cnt_next == '0)
            state_next = IDLE;
        else
            state_next = SHIFT;
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge flop_clk or posedge rst) begin
        if (rst) begin
            q          <= RESET_VAL;
            shadow     <= '0;
            cnt        <= '0;
            state      <= IDLE;
            shift_full <= 1'b0;
            upd_ack    <= 1'b0;
            upd_err    <= 1'b0;
        end else begin
            if (set)
                q <= '1;
            else if (upd_take)
                q <= shadow_data;
            else if (load_en)
                q <= d;

            // Capture samples the pre-update q, and update reads the pre-capture shadow.
            if (shift_en)
                shadow <= {shadow[CHAIN_W-2:0], shift_i};
            else if (capture)
                shadow <= capture_word;

            cnt        <= cnt_next;
            state      <= state_next;
            shift_full <= (state_next == FULL);
            upd_ack    <= upd_take;
            upd_err    <= update && !upd_take;
        end
    end

endmodule

// File: tb/tb_scan_reg_bank.sv
// Scoreboard bench for scan_reg_bank: driver pushes model expectations, a negedge monitor pops and compares.
// Define SCAN_PARITY_EN for the bench and RTL together to exercise the parity chain.
`timescale 1ns/1ps
module tb_scan_reg_bank;
    localparam int W = 8;
`ifdef SCAN_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic         flop_clk = 1'b0;
    logic         rst, set, load_en, shift_en, shift_i, capture, update;
    logic [W-1:0] d, q;
    logic         shift_o, shift_full, upd_ack, upd_err;
    int           total = 0;
    int           bad   = 0;

    typedef struct { logic [W-1:0] q; logic full; logic so; } stat_t;
    typedef struct { logic ack; logic err; logic [W-1:0] q; } resp_t;
    stat_t stat_q[$];
    resp_t resp_q[$];

    // Reference model: live value, chain contents (MSB leaves first) and number of staged bits.
    logic [W-1:0] m_q;
    logic [L-1:0] m_sh;
    int           m_cnt;

    scan_reg_bank #(.WIDTH(W)) dut (
        .flop_clk  (flop_clk),
        .rst       (rst),
        .set       (set),
        .load_en   (load_en),
        .d         (d),
        .q         (q),
        .shift_en  (shift_en),
        .shift_i   (shift_i),
        .shift_o   (shift_o),
        .capture   (capture),
        .update    (update),
        .shift_full(shift_full),
        .upd_ack   (upd_ack),
        .upd_err   (upd_err)
    );

    always #5 flop_clk = ~flop_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] data_of(input logic [L-1:0] s);
        return s[L-1 -: W];
    endfunction

    function automatic logic par_good(input logic [L-1:0] s);
`ifdef SCAN_PARITY_EN
        return ($countones(s) % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [L-1:0] cap_word(input logic [W-1:0] v);
`ifdef SCAN_PARITY_EN
        return {v, ($countones(v) % 2) == 0};
`else
        return v;
`endif
    endfunction

    // One clock of stimulus; the model's next state is computed from the spec rules before the edge.
    task automatic cyc(input logic s, input logic ld, input logic [W-1:0] dd,
                       input logic se, input logic si, input logic cap, input logic upd);
        logic [W-1:0] nq;
        logic [L-1:0] nsh;
        int           ncnt;
        logic         acc, take;
        stat_t        st;
        resp_t        rs;
        @(negedge flop_clk);
        set = s; load_en = ld; d = dd; shift_en = se; shift_i = si; capture = cap; update = upd;
        acc  = upd && (m_cnt == L) && !se;
        take = acc && par_good(m_sh);
        nq   = s ? {W{1'b1}} : take ? data_of(m_sh) : ld ? dd : m_q;
        nsh  = se ? {m_sh[L-2:0], si} : cap ? cap_word(m_q) : m_sh;
        ncnt = se ? ((m_cnt < L) ? m_cnt + 1 : L) : cap ? L : acc ? 0 : m_cnt;
        @(posedge flop_clk);
        #1;
        m_q = nq; m_sh = nsh; m_cnt = ncnt;
        st.q = m_q; st.full = (m_cnt == L); st.so = m_sh[L-1];
        stat_q.push_back(st);
        if (upd) begin
            rs.ack = take; rs.err = !take; rs.q = nq;
            resp_q.push_back(rs);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Word goes MSB first; in the parity build an odd-parity bit follows (inverted when par_bad).
    task automatic shift_word(input logic [W-1:0] w, input logic par_bad);
        for (int i = W - 1; i >= 0; i--)
            cyc(1'b0, 1'b0, '0, 1'b1, w[i], 1'b0, 1'b0);
`ifdef SCAN_PARITY_EN
        cyc(1'b0, 1'b0, '0, 1'b1, (~^w) ^ par_bad, 1'b0, 1'b0);
`endif
    endtask

    task automatic do_reset();
        @(negedge flop_clk);
        #2;
        set = 0; load_en = 0; d = '0; shift_en = 0; shift_i = 0; capture = 0; update = 0;
        rst = 1'b1;
        stat_q.delete();
        resp_q.delete();
        m_q = '0; m_sh = '0; m_cnt = 0;
        #1;
        check("rst_q", 64'(q), 64'(0));
        check("rst_full", 64'(shift_full), 64'(0));
        check("rst_shift_o", 64'(shift_o), 64'(0));
        @(negedge flop_clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: per-cycle state record, plus an update response whenever the DUT pulses ack or err.
    initial begin
        stat_t st;
        resp_t rs;
        forever begin
            @(negedge flop_clk);
            if (stat_q.size() != 0) begin
                st = stat_q.pop_front();
                check("mon_q", 64'(q), 64'(st.q));
                check("mon_full", 64'(shift_full), 64'(st.full));
                check("mon_shift_o", 64'(shift_o), 64'(st.so));
            end
            if (upd_ack || upd_err) begin
                if (resp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_extra: ack=%0b err=%0b with no update pending at %0t", upd_ack, upd_err, $time);
                end else begin
                    rs = resp_q.pop_front();
                    check("resp_ack", 64'(upd_ack), 64'(rs.ack));
                    check("resp_err", 64'(upd_err), 64'(rs.err));
                    check("resp_q", 64'(q), 64'(rs.q));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        rst = 1'b1;
        set = 0; load_en = 0; d = '0; shift_en = 0; shift_i = 0; capture = 0; update = 0;
        m_q = '0; m_sh = '0; m_cnt = 0;
        #1;
        check("init_q", 64'(q), 64'(0));
        check("init_full", 64'(shift_full), 64'(0));
        @(negedge flop_clk);
        #2;
        rst = 1'b0;

        // Full word then update.
        shift_word(8'hA5, 1'b0);
        check("a5_full", 64'(shift_full), 64'(1));
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("a5_q", 64'(q), 64'(8'hA5));
        check("a5_ack", 64'(upd_ack), 64'(1));
        check("a5_full_clr", 64'(shift_full), 64'(0));
        idle();
        check("a5_ack_pulse", 64'(upd_ack), 64'(0));

        // Partial word: update rejected, count retained.
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("part_err", 64'(upd_err), 64'(1));
        check("part_q", 64'(q), 64'(8'hA5));
        check("part_full", 64'(shift_full), 64'(0));
        for (int i = 5; i < L; i++)
            cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("part_retained_full", 64'(shift_full), 64'(1));
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Capture then shift out MSB first.
        cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("cap_full", 64'(shift_full), 64'(1));
        pat = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            check("cap_shift_o", 64'(shift_o), 64'(pat[7-k]));
            cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("cap_still_full", 64'(shift_full), 64'(1));

        // q priority: update over load, set over update.
        shift_word(8'h22, 1'b0);
        cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        check("prio_upd_q", 64'(q), 64'(8'h22));
        shift_word(8'h22, 1'b0);
        cyc(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        check("prio_set_q", 64'(q), 64'(8'hFF));
        check("prio_set_ack", 64'(upd_ack), 64'(1));
        check("prio_set_full", 64'(shift_full), 64'(0));

`ifdef SCAN_PARITY_EN
        shift_word(8'h01, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("par_bad_err", 64'(upd_err), 64'(1));
        check("par_bad_q", 64'(q), 64'(8'hFF));
        check("par_bad_full", 64'(shift_full), 64'(0));
        shift_word(8'h01, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("par_good_ack", 64'(upd_ack), 64'(1));
        check("par_good_q", 64'(q), 64'(8'h01));
`endif

        // Async reset in the middle of a partial word.
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < L - 1; i++)
            cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_discard_full", 64'(shift_full), 64'(0));

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            cyc($urandom_range(0, 99) < 5,
                $urandom_range(0, 99) < 20,
                W'($urandom),
                $urandom_range(0, 99) < 45,
                1'($urandom),
                $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 20);
        end

        idle();
        idle();
        @(negedge flop_clk);
        #1;
        check("resp_drain", 64'(resp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
